// File: rtl/fp_op_sequencer_pkg.sv
// rtl/fp_op_sequencer_pkg.sv - shared state encodings, widths and Op stepping helper
package fp_seq_pkg;

   localparam int OP_WIDTH        = 4;
   localparam int LAST_OP_DEFAULT = 4;

   typedef enum logic [1:0] {
      S_STOP   = 2'd0,
      S_AUTO   = 2'd1,
      S_MANUAL = 2'd2
   } state_e;

   // Anything at or above the last index wraps, so a corrupted Op recovers to 0.
   function automatic logic [OP_WIDTH-1:0] next_op(input logic [OP_WIDTH-1:0] x,
                                                   input logic [OP_WIDTH-1:0] last);
      return (x >= last) ? '0 : x + OP_WIDTH'(1);
   endfunction

endpackage

// File: rtl/fp_op_sequencer_if.sv
// rtl/fp_op_sequencer_if.sv - control inputs and Op/status outputs of the sequencer
interface fp_op_sequencer_if;
   import fp_seq_pkg::*;

   logic                Boton;
   logic                Modo;
   logic                run;
   logic [OP_WIDTH-1:0] Op;
   logic                avance;
   logic                boton_db;
   logic                boton_pulse;
   logic [1:0]          estado;

   modport master (
      output Boton, Modo, run,
      input  Op, avance, boton_db, boton_pulse, estado
   );

   modport slave (
      input  Boton, Modo, run,
      output Op, avance, boton_db, boton_pulse, estado
   );
endinterface

// File: rtl/fp_op_sequencer_button_debouncer.sv
// rtl/fp_op_sequencer_button_debouncer.sv - 2-flop synchronizer, stability counter, rising-edge pulse
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise_pulse
);
   localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          pulse_q, pulse_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      level_d = level_q;
      pulse_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = ~level_q;
            pulse_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level      = level_q;
   assign rise_pulse = pulse_q;
endmodule

// File: rtl/fp_op_sequencer.sv
// rtl/fp_op_sequencer.sv - steps Op through 0..LAST_OP from an auto tick or a debounced button
module fp_op_sequencer
   import fp_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int AUTO_PERIOD     = 8,
   parameter int LAST_OP         = LAST_OP_DEFAULT
) (
   input logic              clk,
   input logic              rst_n,
   fp_op_sequencer_if.slave seq_io
);
   localparam int                  TW       = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
   localparam logic [TW-1:0]       TICK_MAX = TW'(AUTO_PERIOD - 1);
   localparam logic [OP_WIDTH-1:0] OP_LAST  = OP_WIDTH'(LAST_OP);

   state_e              state_q, state_d;
   logic [TW-1:0]       tick_q, tick_d;
   logic [OP_WIDTH-1:0] op_q, op_d;
   logic                avance_q, avance_d;
   logic                db_level, db_pulse;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (seq_io.Boton),
      .level     (db_level),
      .rise_pulse(db_pulse)
   );

   // A step only happens when the state is unchanged this cycle, so a run drop
   // or mode switch cancels a pending tick or button pulse.
   always_comb begin
      state_d  = S_STOP;
      tick_d   = '0;
      op_d     = op_q;
      avance_d = 1'b0;
      if (seq_io.run) begin
         state_d = seq_io.Modo ? S_MANUAL : S_AUTO;
      end
      if (state_q == state_d) begin
         case (state_q)
            S_AUTO: begin
               if (tick_q == TICK_MAX) begin
                  op_d     = next_op(op_q, OP_LAST);
                  avance_d = 1'b1;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            S_MANUAL: begin
               if (db_pulse) begin
                  op_d     = next_op(op_q, OP_LAST);
                  avance_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_STOP;
         tick_q   <= '0;
         op_q     <= '0;
         avance_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         op_q     <= op_d;
         avance_q <= avance_d;
      end
   end

   assign seq_io.Op          = op_q;
   assign seq_io.avance      = avance_q;
   assign seq_io.boton_db    = db_level;
   assign seq_io.boton_pulse = db_pulse;
   assign seq_io.estado      = state_q;
endmodule

// File: tb/tb_fp_op_sequencer.sv
// tb/tb_fp_op_sequencer.sv - directed self-checking bench for fp_op_sequencer
module tb_fp_op_sequencer;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   fp_op_sequencer_if sif ();

   fp_op_sequencer #(
      .DEBOUNCE_CYCLES(3),
      .AUTO_PERIOD    (4),
      .LAST_OP        (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .seq_io(sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Press for 8 cycles, release for 8; returns how many avance strobes were seen.
   task automatic press(output int n_av);
      n_av = 0;
      sif.Boton = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         n_av += int'(sif.avance);
      end
      sif.Boton = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         n_av += int'(sif.avance);
      end
   endtask

   initial begin
      int n_av;
      int n_db;
      logic [31:0] exp_op;
      logic [31:0] seq5 [5];
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      sif.Boton = 1'b0;
      sif.Modo  = 1'b0;
      sif.run   = 1'b0;
      seq5[0] = 1; seq5[1] = 2; seq5[2] = 3; seq5[3] = 4; seq5[4] = 0;

      cyc(); cyc();
      check("rst_op", sif.Op, 0);
      check("rst_avance", sif.avance, 0);
      check("rst_db", sif.boton_db, 0);
      check("rst_pulse", sif.boton_pulse, 0);
      check("rst_estado", sif.estado, 0);
      rst_n = 1'b1;
      cyc();

      // Automatic stepping: strobes every 4 cycles after entry, Op 1,2,3,4,0.
      sif.run = 1'b1;
      cyc();
      check("auto_estado", sif.estado, 1);
      for (int i = 1; i <= 20; i++) begin
         cyc();
         check($sformatf("auto_avance_%0d", i), sif.avance, (i % 4 == 0) ? 1 : 0);
         if (i % 4 == 0) check($sformatf("auto_op_%0d", i), sif.Op, seq5[i/4 - 1]);
      end

      // Manual: held press debounces after 5 cycles, one pulse, one step.
      sif.Modo = 1'b1;
      cyc();
      check("man_estado", sif.estado, 2);
      check("man_op0", sif.Op, 0);
      sif.Boton = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         check($sformatf("man_db_%0d", i), sif.boton_db, (i >= 5) ? 1 : 0);
         check($sformatf("man_pulse_%0d", i), sif.boton_pulse, (i == 5) ? 1 : 0);
         check($sformatf("man_avance_%0d", i), sif.avance, (i == 6) ? 1 : 0);
      end
      check("man_op1", sif.Op, 1);
      sif.Boton = 1'b0;
      n_av = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         n_av += int'(sif.avance);
      end
      check("man_release_avance", n_av, 0);
      check("man_release_db", sif.boton_db, 0);

      // Glitches of 1 and 2 cycles never reach the debounced level.
      n_av = 0;
      n_db = 0;
      sif.Boton = 1'b1;
      cyc();
      sif.Boton = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         n_av += int'(sif.avance);
         n_db += int'(sif.boton_db);
      end
      sif.Boton = 1'b1;
      cyc(); cyc();
      sif.Boton = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         n_av += int'(sif.avance);
         n_db += int'(sif.boton_db);
      end
      check("glitch_db", n_db, 0);
      check("glitch_avance", n_av, 0);
      check("glitch_op", sif.Op, 1);

      // Auto at tick 2, freeze for 5 cycles, then a full period after restore.
      sif.Modo = 1'b0;
      cyc(); cyc(); cyc();
      sif.run = 1'b0;
      n_av = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         n_av += int'(sif.avance);
      end
      check("stop_avance", n_av, 0);
      check("stop_op", sif.Op, 1);
      check("stop_estado", sif.estado, 0);
      sif.run = 1'b1;
      cyc();
      for (int i = 1; i <= 4; i++) begin
         cyc();
         check($sformatf("resume_avance_%0d", i), sif.avance, (i == 4) ? 1 : 0);
      end
      check("resume_op", sif.Op, 2);

      // run drops in the cycle a tick advance is due: the step is dropped.
      cyc(); cyc(); cyc();
      sif.run = 1'b0;
      cyc();
      check("drop_avance", sif.avance, 0);
      check("drop_op", sif.Op, 2);

      // Manual presses: 2 -> 3 -> 4 -> 0, then five more for 1,2,3,4,0.
      sif.run  = 1'b1;
      sif.Modo = 1'b1;
      cyc();
      exp_op = 2;
      for (int k = 0; k < 3; k++) begin
         press(n_av);
         exp_op = (exp_op == 4) ? 0 : exp_op + 1;
         check($sformatf("pre_press_av_%0d", k), n_av, 1);
      end
      check("pre_press_op", sif.Op, exp_op);
      check("pre_press_op_zero", sif.Op, 0);
      for (int k = 0; k < 5; k++) begin
         press(n_av);
         check($sformatf("press_av_%0d", k), n_av, 1);
         check($sformatf("press_op_%0d", k), sif.Op, seq5[k]);
      end

      // Reach Op=3 with the button held, then reset asynchronously mid-cycle.
      press(n_av);
      press(n_av);
      sif.Boton = 1'b1;
      for (int i = 0; i < 8; i++) cyc();
      check("pre_rst_op", sif.Op, 3);
      check("pre_rst_db", sif.boton_db, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_op", sif.Op, 0);
      check("async_rst_db", sif.boton_db, 0);
      check("async_rst_estado", sif.estado, 0);
      check("async_rst_avance", sif.avance, 0);
      check("async_rst_pulse", sif.boton_pulse, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
